seq_presenter: RTL

Sequence source for the memory game: the counterpart of the input-checker machine. It generates a pseudo-random sequence of 2-bit symbols and plays the first `level` symbols on the LEDs. It then serves the expected symbol on `v1`/`v0` to the checker, stepping on each accepted press. It grows the round on success and ends the game on failure or on reaching the full length.

---
 rtl/seq_pkg.sv | 32 +++
 rtl/lfsr8.sv | 31 +++
 rtl/seq_presenter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
//  Module   : seq_pkg
//  Brief    : Shared types, LFSR taps and symbol decode for seq_presenter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_SHOW_ON    = 3'd2,
    S_SHOW_GAP   = 3'd3,
    S_WAIT_INPUT = 3'd4,
    S_ROUND_OK   = 3'd5,
    S_WIN        = 3'd6,
    S_LOSE       = 3'd7
  } seq_state_t;

  typedef logic [1:0] sym_t;

  // Taps 8,6,5,4 map onto register bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [3:0] sym_onehot(input sym_t s);
    return 4'b0001 << s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr8.sv
// ============================================================================
//  Module   : lfsr8
//  Brief    : Free-running 8-bit Fibonacci LFSR, loads seed on reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr8
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= seed;
    end else begin
      r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/seq_presenter.sv
// ============================================================================
//  Module   : seq_presenter
//  Brief    : Memory-game sequence source: loads, shows and serves symbols.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_presenter
  import seq_pkg::*;
#(
  parameter int         MAX_LEN    = 8,
  parameter int         SHOW_TICKS = 4,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       advance,
  input  logic       fail,
  output logic       v1,
  output logic       v0,
  output logic       check_en,
  output logic [3:0] led,
  output logic [3:0] level,
  output logic       round_ok,
  output logic       won,
  output logic       lost
);

  localparam int DW = $clog2(SHOW_TICKS) + 1;
  localparam int IW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

  localparam logic [3:0]    c_max_level = 4'(MAX_LEN);
  localparam logic [3:0]    c_last_idx  = 4'(MAX_LEN - 1);
  localparam logic [DW-1:0] c_dwell_end = DW'(SHOW_TICKS - 1);

  seq_state_t    r_state;
  logic [3:0]    r_idx;
  logic [3:0]    r_level;
  logic [DW-1:0] r_dwell;
  sym_t          r_seq [MAX_LEN];

  logic [7:0]    w_lfsr;
  logic [IW-1:0] w_sel;
  sym_t          w_sym;
  logic          w_last;
  logic          w_unused_lfsr;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (w_lfsr)
  );

  assign w_sel         = r_idx[IW-1:0];
  assign w_sym         = r_seq[w_sel];
  assign w_last        = (r_idx == r_level - 4'd1);
  assign w_unused_lfsr = &{1'b0, w_lfsr[7:2]};

  // Dwell counts only inside the show states; every other state holds it at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_level <= '0;
      r_dwell <= '0;
    end else begin
      r_dwell <= '0;
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_level <= 4'd1;
          end
        end
        S_LOAD: begin
          if (r_idx == c_last_idx) begin
            r_state <= S_SHOW_ON;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_SHOW_ON: begin
          if (r_dwell == c_dwell_end) begin
            r_state <= S_SHOW_GAP;
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        S_SHOW_GAP: begin
          if (r_dwell != c_dwell_end) begin
            r_dwell <= r_dwell + 1'b1;
          end else if (w_last) begin
            r_state <= S_WAIT_INPUT;
            r_idx   <= '0;
          end else begin
            r_state <= S_SHOW_ON;
            r_idx   <= r_idx + 4'd1;
          end
        end
        S_WAIT_INPUT: begin
          if (fail) begin
            r_state <= S_LOSE;
          end else if (advance) begin
            if (!w_last) begin
              r_idx <= r_idx + 4'd1;
            end else if (r_level == c_max_level) begin
              r_state <= S_WIN;
            end else begin
              r_state <= S_ROUND_OK;
            end
          end
        end
        S_ROUND_OK: begin
          r_state <= S_SHOW_ON;
          r_level <= r_level + 4'd1;
          r_idx   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sequence storage has no reset; its contents are rewritten on every LOAD.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_seq[w_sel] <= w_lfsr[1:0];
    end
  end

  assign check_en = (r_state == S_WAIT_INPUT);
  assign {v1, v0} = check_en ? w_sym : 2'b00;
  assign led      = (r_state == S_SHOW_ON) ? sym_onehot(w_sym) : 4'b0000;
  assign level    = r_level;
  assign round_ok = (r_state == S_ROUND_OK);
  assign won      = (r_state == S_WIN);
  assign lost     = (r_state == S_LOSE);

endmodule

`default_nettype wire
